// File: rtl/flash_boot_pkg.sv
// flash_boot_pkg: shared types and constants for the flash boot sequencer.
// Optional feature macro: FLASH_BOOT_CHECKSUM_EN (checksum width lives here).
package flash_boot_pkg;

    // Width of the additive image checksum carried in the last two image bytes.
    localparam int unsigned CSUM_W = 16;

    typedef enum logic [2:0] {
        RDR_RST,
        ENABLE,
        STREAM,
        CHECK,
        RETRY,
        DONE,
        FAIL
    } boot_state_e;

endpackage

// File: rtl/flash_boot_sequencer_if.sv
// flash_boot_sequencer_if: flash stream, RAM write port, CPU reset and status
// signals of the boot sequencer. master = sequencer, slave = surrounding logic.
interface flash_boot_sequencer_if #(
    parameter int unsigned RAM_ADDR_WIDTH = 16
);
    logic                      restart;
    logic                      rdr_reset_n;
    logic                      flash_read_en;
    logic                      flash_read_active;
    logic [7:0]                flash_tData;
    logic                      flash_tValid;
    logic                      ram_we;
    logic [RAM_ADDR_WIDTH-1:0] ram_addr;
    logic [7:0]                ram_wdata;
    logic                      cpu_reset_n;
    logic                      load_done;
    logic                      load_error;
    logic [1:0]                attempt;

    modport master (
        input  restart, flash_read_active, flash_tData, flash_tValid,
        output rdr_reset_n, flash_read_en, ram_we, ram_addr, ram_wdata,
               cpu_reset_n, load_done, load_error, attempt
    );

    modport slave (
        output restart, flash_read_active, flash_tData, flash_tValid,
        input  rdr_reset_n, flash_read_en, ram_we, ram_addr, ram_wdata,
               cpu_reset_n, load_done, load_error, attempt
    );
endinterface

// File: rtl/flash_boot_checksum.sv
// flash_boot_checksum: 16-bit additive accumulator over image payload bytes.
// Compiled only when FLASH_BOOT_CHECKSUM_EN is defined.
`ifdef FLASH_BOOT_CHECKSUM_EN
module flash_boot_checksum
    import flash_boot_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              clr,
    input  logic              en,
    input  logic [7:0]        data,
    output logic [CSUM_W-1:0] sum
);
    logic [CSUM_W-1:0] sum_q;
    logic [CSUM_W-1:0] sum_d;

    // Clear has priority; otherwise add each enabled byte modulo 2^CSUM_W.
    always_comb begin
        sum_d = sum_q;
        if (clr) begin
            sum_d = '0;
        end else if (en) begin
            sum_d = sum_q + CSUM_W'(data);
        end
    end

    // Accumulator register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum = sum_q;
endmodule
`endif

// File: rtl/flash_boot_sequencer.sv
// flash_boot_sequencer: resets and enables the SPI flash reader, copies the
// streamed image into RAM, retries short/stalled loads, then releases or
// parks the CPU. Optional FLASH_BOOT_CHECKSUM_EN: last two image bytes are a
// little-endian additive checksum of the payload and are not written to RAM.
module flash_boot_sequencer
    import flash_boot_pkg::*;
#(
    parameter int unsigned NUM_BYTES        = 65336,
    parameter int unsigned RAM_ADDR_WIDTH   = 16,
    parameter int unsigned RAM_BASE         = 0,
    parameter int unsigned MAX_RETRIES      = 2,
    parameter int unsigned RDR_RESET_CYCLES = 4,
    parameter int unsigned STALL_CYCLES     = 250000
) (
    input  logic                   clock,
    input  logic                   reset,
    flash_boot_sequencer_if.master bus
);

    // Byte count must hold NUM_BYTES+1, the saturated overrun value.
    localparam int unsigned CNT_W   = $clog2(NUM_BYTES + 2);
    localparam int unsigned STALL_W = $clog2(STALL_CYCLES + 1);
    localparam int unsigned RST_W   = $clog2(RDR_RESET_CYCLES + 1);
`ifdef FLASH_BOOT_CHECKSUM_EN
    localparam int unsigned WR_BYTES = NUM_BYTES - 2;
`else
    localparam int unsigned WR_BYTES = NUM_BYTES;
`endif

    boot_state_e               state_q, state_d;
    logic [RST_W-1:0]          rst_cnt_q, rst_cnt_d;
    logic [STALL_W-1:0]        stall_q, stall_d;
    logic [CNT_W-1:0]          byte_cnt_q, byte_cnt_d;
    logic                      active_q;
    logic [1:0]                attempt_q, attempt_d;
    logic                      rdr_reset_n_q, rdr_reset_n_d;
    logic                      flash_read_en_q, flash_read_en_d;
    logic                      ram_we_q, ram_we_d;
    logic [RAM_ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [7:0]                ram_wdata_q, ram_wdata_d;
    logic                      cpu_reset_n_q, cpu_reset_n_d;
    logic                      load_done_q, load_done_d;
    logic                      load_error_q, load_error_d;
    logic                      take_c;
    logic                      fall_c;
    logic                      csum_ok_c;

    // A byte is accepted only while the reader is enabled for this attempt.
    assign take_c = bus.flash_tValid && ((state_q == ENABLE) || (state_q == STREAM));
    assign fall_c = active_q && !bus.flash_read_active;

`ifdef FLASH_BOOT_CHECKSUM_EN
    logic [7:0]        csum_lo_q, csum_lo_d;
    logic [7:0]        csum_hi_q, csum_hi_d;
    logic [CSUM_W-1:0] csum_sum;
    logic              csum_clr_c;
    logic              csum_en_c;

    assign csum_clr_c = (state_q == RDR_RST);
    assign csum_en_c  = take_c && (byte_cnt_q < CNT_W'(WR_BYTES));
    assign csum_ok_c  = (csum_sum == {csum_hi_q, csum_lo_q});

    // Capture the trailing little-endian checksum bytes as they stream past.
    always_comb begin
        csum_lo_d = csum_lo_q;
        csum_hi_d = csum_hi_q;
        if (state_q == RDR_RST) begin
            csum_lo_d = '0;
            csum_hi_d = '0;
        end else if (take_c && (byte_cnt_q == CNT_W'(NUM_BYTES - 2))) begin
            csum_lo_d = bus.flash_tData;
        end else if (take_c && (byte_cnt_q == CNT_W'(NUM_BYTES - 1))) begin
            csum_hi_d = bus.flash_tData;
        end
    end

    // Received checksum registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            csum_lo_q <= '0;
            csum_hi_q <= '0;
        end else begin
            csum_lo_q <= csum_lo_d;
            csum_hi_q <= csum_hi_d;
        end
    end

    flash_boot_checksum u_csum (
        .clock (clock),
        .reset (reset),
        .clr   (csum_clr_c),
        .en    (csum_en_c),
        .data  (bus.flash_tData),
        .sum   (csum_sum)
    );
`else
    assign csum_ok_c = 1'b1;
`endif

    // RAM write datapath: write accepted bytes the next cycle, advance the
    // address after each write, discard bytes past the image length.
    always_comb begin
        ram_we_d    = 1'b0;
        ram_wdata_d = ram_wdata_q;
        ram_addr_d  = ram_we_q ? (ram_addr_q + RAM_ADDR_WIDTH'(1)) : ram_addr_q;
        byte_cnt_d  = byte_cnt_q;
        if (state_q == RDR_RST) begin
            ram_addr_d = RAM_ADDR_WIDTH'(RAM_BASE);
            byte_cnt_d = '0;
        end else if (take_c) begin
            if (byte_cnt_q < CNT_W'(WR_BYTES)) begin
                ram_we_d    = 1'b1;
                ram_wdata_d = bus.flash_tData;
            end
            if (byte_cnt_q != CNT_W'(NUM_BYTES + 1)) begin
                byte_cnt_d = byte_cnt_q + CNT_W'(1);
            end
        end
    end

    // Sequencer next state and registered-output next values.
    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        stall_d   = stall_q;
        attempt_d = attempt_q;

        case (state_q)
            RDR_RST: begin
                stall_d = '0;
                if (rst_cnt_q == RST_W'(RDR_RESET_CYCLES - 1)) begin
                    rst_cnt_d = '0;
                    state_d   = ENABLE;
                end else begin
                    rst_cnt_d = rst_cnt_q + RST_W'(1);
                end
            end
            ENABLE, STREAM: begin
                state_d = STREAM;
                stall_d = take_c ? '0 : (stall_q + STALL_W'(1));
                if (fall_c && ((byte_cnt_q != '0) || take_c)) begin
                    state_d = CHECK;
                end else if (!take_c && (stall_q == STALL_W'(STALL_CYCLES - 1))) begin
                    state_d = RETRY;
                end
            end
            CHECK: begin
                state_d = ((byte_cnt_q == CNT_W'(NUM_BYTES)) && csum_ok_c) ? DONE : RETRY;
            end
            RETRY: begin
                if (32'(attempt_q) < MAX_RETRIES) begin
                    attempt_d = (attempt_q == 2'd3) ? attempt_q : (attempt_q + 2'd1);
                    state_d   = RDR_RST;
                end else begin
                    state_d = FAIL;
                end
            end
            DONE, FAIL: begin
                if (bus.restart) begin
                    attempt_d = '0;
                    state_d   = RDR_RST;
                end
            end
            default: state_d = RDR_RST;
        endcase

        // Outputs follow the next state so they line up with state_q.
        rdr_reset_n_d   = (state_d != RDR_RST);
        flash_read_en_d = (state_d == ENABLE) || (state_d == STREAM) || (state_d == CHECK);
        load_done_d     = (state_d == DONE);
        load_error_d    = (state_d == FAIL);
        // CPU is released one cycle after DONE is entered.
        cpu_reset_n_d   = (state_q == DONE) && (state_d == DONE);
    end

    // State, counters and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= RDR_RST;
            rst_cnt_q       <= '0;
            stall_q         <= '0;
            byte_cnt_q      <= '0;
            active_q        <= 1'b0;
            attempt_q       <= '0;
            rdr_reset_n_q   <= 1'b0;
            flash_read_en_q <= 1'b0;
            ram_we_q        <= 1'b0;
            ram_addr_q      <= RAM_ADDR_WIDTH'(RAM_BASE);
            ram_wdata_q     <= '0;
            cpu_reset_n_q   <= 1'b0;
            load_done_q     <= 1'b0;
            load_error_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            rst_cnt_q       <= rst_cnt_d;
            stall_q         <= stall_d;
            byte_cnt_q      <= byte_cnt_d;
            active_q        <= bus.flash_read_active;
            attempt_q       <= attempt_d;
            rdr_reset_n_q   <= rdr_reset_n_d;
            flash_read_en_q <= flash_read_en_d;
            ram_we_q        <= ram_we_d;
            ram_addr_q      <= ram_addr_d;
            ram_wdata_q     <= ram_wdata_d;
            cpu_reset_n_q   <= cpu_reset_n_d;
            load_done_q     <= load_done_d;
            load_error_q    <= load_error_d;
        end
    end

    assign bus.rdr_reset_n   = rdr_reset_n_q;
    assign bus.flash_read_en = flash_read_en_q;
    assign bus.ram_we        = ram_we_q;
    assign bus.ram_addr      = ram_addr_q;
    assign bus.ram_wdata     = ram_wdata_q;
    assign bus.cpu_reset_n   = cpu_reset_n_q;
    assign bus.load_done     = load_done_q;
    assign bus.load_error    = load_error_q;
    assign bus.attempt       = attempt_q;

endmodule

// File: tb/tb_flash_boot_sequencer.sv
// tb_flash_boot_sequencer: directed scenarios with random image contents and
// random byte spacing, checked against an image-level reference model.
`timescale 1ns/1ps
module tb_flash_boot_sequencer;

    localparam int unsigned NB    = 16;
    localparam int unsigned AW    = 16;
    localparam int unsigned BASE  = 32'h0000_FFF8;
    localparam int unsigned RETR  = 2;
    localparam int unsigned RRC   = 4;
    localparam int unsigned STALL = 100;
`ifdef FLASH_BOOT_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif
    localparam int unsigned NWR = CSUM ? NB - 2 : NB;

    typedef logic [7:0] bq_t [$];

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    int          checks = 0;
    int          passes = 0;
    int          fails = 0;
    int          bad_cpu = 0;
    int          done_lag = 0;
    int          lowrun = 0;
    logic [23:0] wlog [$];
    int          lowruns [$];

    flash_boot_sequencer_if #(.RAM_ADDR_WIDTH(AW)) bus ();

    flash_boot_sequencer #(
        .NUM_BYTES        (NB),
        .RAM_ADDR_WIDTH   (AW),
        .RAM_BASE         (BASE),
        .MAX_RETRIES      (RETR),
        .RDR_RESET_CYCLES (RRC),
        .STALL_CYCLES     (STALL)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Observe RAM writes, reader-reset pulse widths and CPU release timing.
    always @(negedge clock) begin
        if (reset) begin
            lowrun = 0;
        end else begin
            if (bus.ram_we === 1'b1) wlog.push_back({bus.ram_addr, bus.ram_wdata});
            if (bus.rdr_reset_n === 1'b0) begin
                lowrun++;
            end else if (lowrun != 0) begin
                lowruns.push_back(lowrun);
                lowrun = 0;
            end
            if (bus.cpu_reset_n === 1'b1 && bus.load_done !== 1'b1) bad_cpu++;
            if (bus.load_done === 1'b1 && bus.cpu_reset_n !== 1'b1) done_lag++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Reference model: random payload, plus checksum bytes when enabled.
    function automatic bq_t make_image();
        bq_t         img;
        int unsigned sum = 0;
        for (int i = 0; i < int'(NWR); i++) begin
            img.push_back(8'($urandom_range(0, 255)));
            sum += 32'(img[i]);
        end
        if (CSUM) begin
            img.push_back(sum[7:0]);
            img.push_back(sum[15:8]);
        end
        return img;
    endfunction

    // Reference model: would a transfer of exactly these bytes be accepted?
    function automatic bit image_ok(input bq_t img);
        int unsigned sum = 0;
        if (img.size() != int'(NB)) return 1'b0;
        if (!CSUM) return 1'b1;
        for (int i = 0; i < int'(NB) - 2; i++) sum += 32'(img[i]);
        return 16'(sum) == {img[NB-1], img[NB-2]};
    endfunction

    task automatic check_reset_vals(input string tag);
        chk({tag, " rdr_reset_n"}, 32'(bus.rdr_reset_n), 32'(0));
        chk({tag, " read_en"},     32'(bus.flash_read_en), 32'(0));
        chk({tag, " ram_we"},      32'(bus.ram_we), 32'(0));
        chk({tag, " ram_addr"},    32'(bus.ram_addr), 32'(16'(BASE)));
        chk({tag, " ram_wdata"},   32'(bus.ram_wdata), 32'(0));
        chk({tag, " cpu_reset_n"}, 32'(bus.cpu_reset_n), 32'(0));
        chk({tag, " load_done"},   32'(bus.load_done), 32'(0));
        chk({tag, " load_error"},  32'(bus.load_error), 32'(0));
        chk({tag, " attempt"},     32'(bus.attempt), 32'(0));
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        bus.restart = 1'b0;
        bus.flash_read_active = 1'b0;
        bus.flash_tValid = 1'b0;
        bus.flash_tData = 8'h00;
        cyc(3);
        reset = 1'b0;
        wlog.delete();
        lowruns.delete();
        bad_cpu = 0;
        done_lag = 0;
    endtask

    task automatic wait_en(input string tag);
        int n = 0;
        while (bus.flash_read_en !== 1'b1 && n < 1000) begin
            cyc(1);
            n++;
        end
        chk({tag, " enable seen"}, 32'(bus.flash_read_en), 32'(1));
    endtask

    task automatic wait_status(input string tag);
        int n = 0;
        while (bus.load_done !== 1'b1 && bus.load_error !== 1'b1 && n < 3000) begin
            cyc(1);
            n++;
        end
        chk({tag, " status seen"}, 32'(bus.load_done | bus.load_error), 32'(1));
        cyc(2);
    endtask

    // Flash reader model: one-cycle valids with random gaps; optionally drops
    // active at the end, sometimes in the same cycle as the last byte.
    task automatic stream(input bq_t img, input bit drop, input string tag);
        bit together;
        together = 1'($urandom_range(0, 1));
        wait_en(tag);
        bus.flash_read_active = 1'b1;
        for (int i = 0; i < img.size(); i++) begin
            cyc(1 + int'($urandom_range(0, 2)));
            bus.flash_tValid = 1'b1;
            bus.flash_tData = img[i];
            if (drop && together && i == img.size() - 1) bus.flash_read_active = 1'b0;
            cyc(1);
            bus.flash_tValid = 1'b0;
        end
        if (drop) begin
            bus.flash_read_active = 1'b0;
            cyc(1);
        end
    endtask

    task automatic check_writes(input bq_t img, input string tag);
        int n;
        cyc(3);
        n = (img.size() < int'(NWR)) ? img.size() : int'(NWR);
        chk({tag, " write count"}, 32'(wlog.size()), 32'(n));
        for (int i = 0; i < n && i < wlog.size(); i++)
            chk({tag, " write"}, 32'(wlog[i]), {8'h00, 16'(BASE + 32'(i)), img[i]});
        wlog.delete();
    endtask

    task automatic pulse_restart();
        bus.restart = 1'b1;
        cyc(1);
        bus.restart = 1'b0;
    endtask

    task automatic check_done(input bq_t img, input int exp_att, input string tag);
        chk({tag, " load_done"},   32'(bus.load_done), 32'(image_ok(img)));
        chk({tag, " load_error"},  32'(bus.load_error), 32'(0));
        chk({tag, " cpu_reset_n"}, 32'(bus.cpu_reset_n), 32'(1));
        chk({tag, " read_en off"}, 32'(bus.flash_read_en), 32'(0));
        chk({tag, " attempt"},     32'(bus.attempt), 32'(exp_att));
        chk({tag, " cpu lag"},     32'(done_lag), 32'(1));
        done_lag = 0;
    endtask

    initial begin
        bq_t img, img2, short_img, over_img, part_img;

        // Reset values.
        apply_reset();
        check_reset_vals("reset");

        // Clean load; RAM_BASE near the top so the address wraps.
        img = make_image();
        stream(img, 1'b1, "t1");
        check_writes(img, "t1");
        wait_status("t1");
        check_done(img, 0, "t1");

        // Restart in DONE drops the CPU reset next cycle and reloads.
        pulse_restart();
        chk("t2 cpu after restart", 32'(bus.cpu_reset_n), 32'(0));
        chk("t2 done after restart", 32'(bus.load_done), 32'(0));
        img2 = make_image();
        stream(img2, 1'b1, "t2");
        check_writes(img2, "t2");
        wait_status("t2");
        check_done(img2, 0, "t2");

        // Short first attempt (10 bytes), complete second attempt.
        apply_reset();
        img = make_image();
        short_img = img[0:9];
        stream(short_img, 1'b1, "t3a");
        lowruns.delete();
        check_writes(short_img, "t3a");
        stream(img, 1'b1, "t3b");
        check_writes(img, "t3b");
        wait_status("t3");
        check_done(img, int'(!image_ok(short_img)), "t3");
        chk("t3 reader reset pulses", 32'(lowruns.size()), 32'(1));
        if (lowruns.size() > 0) chk("t3 reader reset width", 32'(lowruns[0]), 32'(RRC));

        // Overrun: one byte too many is discarded and forces a retry.
        pulse_restart();
        over_img = make_image();
        over_img.push_back(8'($urandom_range(0, 255)));
        stream(over_img, 1'b1, "t4a");
        check_writes(over_img, "t4a");
        img = make_image();
        stream(img, 1'b1, "t4b");
        check_writes(img, "t4b");
        wait_status("t4");
        check_done(img, int'(!image_ok(over_img)), "t4");

        // Asynchronous reset mid-stream after byte 7, then a full reload.
        pulse_restart();
        part_img = make_image();
        part_img = part_img[0:6];
        stream(part_img, 1'b0, "t5a");
        reset = 1'b1;
        #1;
        check_reset_vals("t5 midreset");
        bus.flash_read_active = 1'b0;
        cyc(2);
        reset = 1'b0;
        wlog.delete();
        done_lag = 0;
        img = make_image();
        stream(img, 1'b1, "t5b");
        check_writes(img, "t5b");
        wait_status("t5");
        check_done(img, 0, "t5");

        // Reader never produces data: stalls until the retry budget runs out.
        apply_reset();
        wait_status("t6");
        chk("t6 load_error", 32'(bus.load_error), 32'(1));
        chk("t6 load_done", 32'(bus.load_done), 32'(0));
        chk("t6 cpu_reset_n", 32'(bus.cpu_reset_n), 32'(0));
        chk("t6 attempt", 32'(bus.attempt), 32'(RETR));
        chk("t6 read_en off", 32'(bus.flash_read_en), 32'(0));
        chk("t6 no writes", 32'(wlog.size()), 32'(0));
        pulse_restart();
        chk("t6 error cleared", 32'(bus.load_error), 32'(0));
        chk("t6 attempt cleared", 32'(bus.attempt), 32'(0));
        img = make_image();
        stream(img, 1'b1, "t6b");
        check_writes(img, "t6b");
        wait_status("t6b");
        check_done(img, 0, "t6b");

`ifdef FLASH_BOOT_CHECKSUM_EN
        // Known image: fourteen 0x01 bytes, checksum 0x000E.
        pulse_restart();
        img.delete();
        for (int i = 0; i < 14; i++) img.push_back(8'h01);
        img.push_back(8'h0E);
        img.push_back(8'h00);
        stream(img, 1'b1, "t7");
        check_writes(img, "t7");
        wait_status("t7");
        check_done(img, 0, "t7");

        // Corrupted checksum byte: every attempt rejected.
        pulse_restart();
        img[14] = 8'h0F;
        for (int a = 0; a <= int'(RETR); a++) begin
            stream(img, 1'b1, "t8");
            check_writes(img, "t8");
        end
        wait_status("t8");
        chk("t8 load_error", 32'(bus.load_error), 32'(!image_ok(img)));
        chk("t8 load_done", 32'(bus.load_done), 32'(0));
        chk("t8 cpu_reset_n", 32'(bus.cpu_reset_n), 32'(0));
        chk("t8 attempt", 32'(bus.attempt), 32'(RETR));
`endif

        chk("cpu released only when done", 32'(bad_cpu), 32'(0));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
